// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch decision, next-PC select and retired-branch statistics
module branch_resolver #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  valid_in,
    input  logic [2:0]            br_op,
    input  logic                  more,
    input  logic                  equal,
    input  logic                  less,
    input  logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic [DATA_WIDTH-1:0] br_target,
    output logic                  taken,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  taken_q,
    output logic [CNT_WIDTH-1:0]  cnt_cycles,
    output logic [CNT_WIDTH-1:0]  cnt_uncond,
    output logic [CNT_WIDTH-1:0]  cnt_cond,
    output logic [CNT_WIDTH-1:0]  cnt_cond_tkn,
    output logic                  flag_err
);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BLEZ = 3'b011,
        OP_BGTZ = 3'b100,
        OP_BLTZ = 3'b101,
        OP_BGEZ = 3'b110,
        OP_JUMP = 3'b111
    } br_op_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    br_op_e op;
    logic   is_cond;
    logic   is_jump;
    logic   flags_ok;
    logic   cond_true;
    logic   qual;

    logic                 taken_hold_q,   taken_hold_d;
    logic [CNT_WIDTH-1:0] cnt_cycles_q,   cnt_cycles_d;
    logic [CNT_WIDTH-1:0] cnt_uncond_q,   cnt_uncond_d;
    logic [CNT_WIDTH-1:0] cnt_cond_q,     cnt_cond_d;
    logic [CNT_WIDTH-1:0] cnt_cond_tkn_q, cnt_cond_tkn_d;
    logic                 flag_err_q,     flag_err_d;

    assign op      = br_op_e'(br_op);
    assign is_jump = (op == OP_JUMP);
    assign is_cond = (op != OP_NONE) && (op != OP_JUMP);
    assign qual    = en & valid_in;

    // Comparator flags are trusted only when exactly one of them is asserted.
    assign flags_ok = (more & ~equal & ~less) |
                      (~more & equal & ~less) |
                      (~more & ~equal & less);

    // Raw condition for each branch class, before the flag-integrity gate.
    always_comb begin
        cond_true = 1'b0;
        unique case (op)
            OP_NONE: cond_true = 1'b0;
            OP_BEQ:  cond_true = equal;
            OP_BNE:  cond_true = ~equal;
            OP_BLEZ: cond_true = less | equal;
            OP_BGTZ: cond_true = more;
            OP_BLTZ: cond_true = less;
            OP_BGEZ: cond_true = more | equal;
            OP_JUMP: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Decision and PC select stay purely combinational: a corrupt flag set
    // falls through to sequential fetch, jumps ignore the flags entirely.
    always_comb begin
        taken   = 1'b0;
        next_pc = pc_plus4;
        if (is_jump) begin
            taken = 1'b1;
        end else if (is_cond) begin
            taken = cond_true & flags_ok;
        end
        if (taken) begin
            next_pc = br_target;
        end
    end

    // Next-state for the registered decision, statistics and sticky error.
    always_comb begin
        taken_hold_d   = taken_hold_q;
        cnt_cycles_d   = cnt_cycles_q;
        cnt_uncond_d   = cnt_uncond_q;
        cnt_cond_d     = cnt_cond_q;
        cnt_cond_tkn_d = cnt_cond_tkn_q;
        flag_err_d     = flag_err_q;
        if (en) begin
            cnt_cycles_d = cnt_cycles_q + CNT_ONE;
        end
        if (qual) begin
            taken_hold_d = taken;
            if (is_jump) begin
                cnt_uncond_d = cnt_uncond_q + CNT_ONE;
            end
            if (is_cond) begin
                cnt_cond_d = cnt_cond_q + CNT_ONE;
                if (taken) begin
                    cnt_cond_tkn_d = cnt_cond_tkn_q + CNT_ONE;
                end
                if (!flags_ok) begin
                    flag_err_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset wins over any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_hold_q   <= 1'b0;
            cnt_cycles_q   <= '0;
            cnt_uncond_q   <= '0;
            cnt_cond_q     <= '0;
            cnt_cond_tkn_q <= '0;
            flag_err_q     <= 1'b0;
        end else begin
            taken_hold_q   <= taken_hold_d;
            cnt_cycles_q   <= cnt_cycles_d;
            cnt_uncond_q   <= cnt_uncond_d;
            cnt_cond_q     <= cnt_cond_d;
            cnt_cond_tkn_q <= cnt_cond_tkn_d;
            flag_err_q     <= flag_err_d;
        end
    end

    assign taken_q      = taken_hold_q;
    assign cnt_cycles   = cnt_cycles_q;
    assign cnt_uncond   = cnt_uncond_q;
    assign cnt_cond     = cnt_cond_q;
    assign cnt_cond_tkn = cnt_cond_tkn_q;
    assign flag_err     = flag_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;

    localparam int SEL_TAKEN   = 0;
    localparam int SEL_NEXTPC  = 1;
    localparam int SEL_TAKENQ  = 2;
    localparam int SEL_CYCLES  = 3;
    localparam int SEL_UNCOND  = 4;
    localparam int SEL_COND    = 5;
    localparam int SEL_TKN     = 6;
    localparam int SEL_FLAGERR = 7;
    localparam int SEL_UNC4    = 8;
    localparam int SEL_CYC4    = 9;

    logic        clk;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [2:0]  br_op;
    logic        more;
    logic        equal;
    logic        less;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    logic        taken;
    logic [31:0] next_pc;
    logic        taken_q;
    logic [31:0] cnt_cycles;
    logic [31:0] cnt_uncond;
    logic [31:0] cnt_cond;
    logic [31:0] cnt_cond_tkn;
    logic        flag_err;

    logic        taken4;
    logic [31:0] next_pc4;
    logic        taken_q4;
    logic [3:0]  cnt_cycles4;
    logic [3:0]  cnt_uncond4;
    logic [3:0]  cnt_cond4;
    logic [3:0]  cnt_cond_tkn4;
    logic        flag_err4;

    branch_resolver #(.DATA_WIDTH(32), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .br_op(br_op),
        .more(more), .equal(equal), .less(less),
        .pc_plus4(pc_plus4), .br_target(br_target),
        .taken(taken), .next_pc(next_pc), .taken_q(taken_q),
        .cnt_cycles(cnt_cycles), .cnt_uncond(cnt_uncond), .cnt_cond(cnt_cond),
        .cnt_cond_tkn(cnt_cond_tkn), .flag_err(flag_err)
    );

    branch_resolver #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .br_op(br_op),
        .more(more), .equal(equal), .less(less),
        .pc_plus4(pc_plus4), .br_target(br_target),
        .taken(taken4), .next_pc(next_pc4), .taken_q(taken_q4),
        .cnt_cycles(cnt_cycles4), .cnt_uncond(cnt_uncond4), .cnt_cond(cnt_cond4),
        .cnt_cond_tkn(cnt_cond_tkn4), .flag_err(flag_err4)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mon_act;
    logic [2:0]  tkn_tab [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_TAKEN:   return {31'b0, taken};
            SEL_NEXTPC:  return next_pc;
            SEL_TAKENQ:  return {31'b0, taken_q};
            SEL_CYCLES:  return cnt_cycles;
            SEL_UNCOND:  return cnt_uncond;
            SEL_COND:    return cnt_cond;
            SEL_TKN:     return cnt_cond_tkn;
            SEL_FLAGERR: return {31'b0, flag_err};
            SEL_UNC4:    return {28'b0, cnt_uncond4};
            SEL_CYC4:    return {28'b0, cnt_cycles4};
            default:     return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_v(input int sel, input logic [31:0] v, input int dly, input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [2:0] op,
                        input logic [2:0] mel, input logic [31:0] p4, input logic [31:0] tg);
        @(posedge clk);
        #1;
        rst       = r;
        en        = e;
        valid_in  = v;
        br_op     = op;
        more      = mel[2];
        equal     = mel[1];
        less      = mel[0];
        pc_plus4  = p4;
        br_target = tg;
    endtask

    // Monitor: compare every expectation whose cycle stamp has come due.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                mon_act = actual(sb[i].sel);
                n_checks++;
                if (mon_act !== sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", sb[i].name, cyc, mon_act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] mel;
        logic [2:0] row;
        logic       exp_t_bit;

        tkn_tab[0] = 3'b000;
        tkn_tab[1] = 3'b010;
        tkn_tab[2] = 3'b101;
        tkn_tab[3] = 3'b011;
        tkn_tab[4] = 3'b100;
        tkn_tab[5] = 3'b001;
        tkn_tab[6] = 3'b110;
        tkn_tab[7] = 3'b111;

        rst = 1'b1; en = 1'b0; valid_in = 1'b0; br_op = 3'b000;
        more = 1'b0; equal = 1'b1; less = 1'b0;
        pc_plus4 = 32'h4; br_target = 32'h0;

        // 1: reset, comb path live during reset, then 10 running cycles
        step(1, 0, 0, 3'b000, 3'b010, 32'h4, 32'h0);
        step(1, 0, 0, 3'b111, 3'b010, 32'h4, 32'h80);
        expect_v(SEL_TAKEN,   1,     0, "rst_taken_comb");
        expect_v(SEL_NEXTPC,  32'h80, 0, "rst_next_pc_comb");
        expect_v(SEL_TAKENQ,  0, 1, "rst_taken_q");
        expect_v(SEL_CYCLES,  0, 1, "rst_cycles");
        expect_v(SEL_UNCOND,  0, 1, "rst_uncond");
        expect_v(SEL_COND,    0, 1, "rst_cond");
        expect_v(SEL_TKN,     0, 1, "rst_cond_tkn");
        expect_v(SEL_FLAGERR, 0, 1, "rst_flag_err");
        expect_v(SEL_UNC4,    0, 1, "rst_uncond4");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 3'b000, 3'b010, 32'h4, 32'h0);
        expect_v(SEL_CYCLES, 10, 1, "cycles_10");

        // 2: single taken BEQ
        step(0, 1, 1, 3'b001, 3'b010, 32'h104, 32'h200);
        expect_v(SEL_TAKEN,  1,       0, "beq_taken");
        expect_v(SEL_NEXTPC, 32'h200, 0, "beq_next_pc");
        expect_v(SEL_COND,   1, 1, "beq_cnt_cond");
        expect_v(SEL_TKN,    1, 1, "beq_cnt_cond_tkn");
        expect_v(SEL_TAKENQ, 1, 1, "beq_taken_q");

        // 3: reset with a valid JUMP pending, then sweep ops x one-hot flags
        step(1, 1, 1, 3'b111, 3'b010, 32'h104, 32'h200);
        expect_v(SEL_COND,   0, 1, "rst_mid_cond");
        expect_v(SEL_UNCOND, 0, 1, "rst_mid_uncond");
        for (int op = 0; op < 8; op++) begin
            for (int f = 0; f < 3; f++) begin
                mel = 3'b100 >> f;
                row = tkn_tab[op];
                exp_t_bit = row[2 - f];
                step(0, 1, 1, 3'(op), mel, 32'h1000 + 32'(op * 16 + f * 4), 32'h8000 + 32'(op));
                expect_v(SEL_TAKEN, {31'b0, exp_t_bit}, 0, $sformatf("sweep_taken_op%0d_f%0d", op, f));
                expect_v(SEL_NEXTPC, exp_t_bit ? 32'h8000 + 32'(op) : 32'h1000 + 32'(op * 16 + f * 4), 0,
                         $sformatf("sweep_next_pc_op%0d_f%0d", op, f));
            end
        end
        expect_v(SEL_COND,    18, 1, "sweep_cnt_cond");
        expect_v(SEL_UNCOND,  3,  1, "sweep_cnt_uncond");
        expect_v(SEL_TKN,     9,  1, "sweep_cnt_cond_tkn");
        expect_v(SEL_CYCLES,  24, 1, "sweep_cnt_cycles");
        expect_v(SEL_FLAGERR, 0,  1, "sweep_flag_err");
        expect_v(SEL_UNC4,    3,  1, "sweep_uncond4");

        // 4: halted CPU, valid JUMP must not count
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 3'b111, 3'b010, 32'h300, 32'h400);
            expect_v(SEL_TAKEN,  1,       0, "halt_taken");
            expect_v(SEL_NEXTPC, 32'h400, 0, "halt_next_pc");
        end
        expect_v(SEL_CYCLES, 24, 1, "halt_cycles");
        expect_v(SEL_UNCOND, 3,  1, "halt_uncond");
        expect_v(SEL_COND,   18, 1, "halt_cond");
        expect_v(SEL_TAKENQ, 1,  1, "halt_taken_q");

        // 5: corrupt flags on BGTZ; sticky error; JUMP ignores flags
        step(0, 1, 1, 3'b100, 3'b101, 32'h500, 32'h600);
        expect_v(SEL_TAKEN,   0,       0, "bad_bgtz_taken");
        expect_v(SEL_NEXTPC,  32'h500, 0, "bad_bgtz_next_pc");
        expect_v(SEL_FLAGERR, 1, 1, "bad_bgtz_flag_err");
        expect_v(SEL_COND,    19, 1, "bad_bgtz_cond");
        expect_v(SEL_TKN,     9, 1, "bad_bgtz_tkn");
        expect_v(SEL_TAKENQ,  0, 1, "bad_bgtz_taken_q");
        step(0, 1, 1, 3'b111, 3'b101, 32'h500, 32'h600);
        expect_v(SEL_TAKEN,   1,       0, "bad_jump_taken");
        expect_v(SEL_NEXTPC,  32'h600, 0, "bad_jump_next_pc");
        expect_v(SEL_UNCOND,  4, 1, "bad_jump_uncond");
        for (int i = 0; i < 3; i++) step(0, 1, 1, 3'b001, 3'b010, 32'h700, 32'h800);
        expect_v(SEL_FLAGERR, 1,  1, "flag_err_sticky");
        expect_v(SEL_COND,    22, 1, "post_err_cond");
        expect_v(SEL_TKN,     12, 1, "post_err_tkn");

        // 6: narrow counters wrap; reset on a valid JUMP cycle clears all
        step(1, 1, 0, 3'b000, 3'b010, 32'h4, 32'h0);
        expect_v(SEL_FLAGERR, 0, 1, "flag_err_cleared");
        expect_v(SEL_UNC4,    0, 1, "wrap_start");
        for (int i = 1; i <= 17; i++) begin
            step(0, 1, 1, 3'b111, 3'b010, 32'h4, 32'h40);
            if (i == 15) expect_v(SEL_UNC4, 15, 1, "uncond4_at_15");
            if (i == 16) begin
                expect_v(SEL_UNC4,   0,  1, "uncond4_wrap");
                expect_v(SEL_UNCOND, 16, 1, "uncond32_16");
            end
        end
        expect_v(SEL_UNC4,   1,  1, "uncond4_after_wrap");
        expect_v(SEL_CYC4,   1,  1, "cycles4_wrap");
        expect_v(SEL_UNCOND, 17, 1, "uncond32_17");
        step(1, 1, 1, 3'b111, 3'b010, 32'h4, 32'h40);
        expect_v(SEL_UNCOND, 0, 1, "rst_jump_uncond");
        expect_v(SEL_UNC4,   0, 1, "rst_jump_uncond4");
        expect_v(SEL_CYCLES, 0, 1, "rst_jump_cycles");
        expect_v(SEL_CYC4,   0, 1, "rst_jump_cycles4");

        for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b000, 3'b010, 32'h4, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
